pingpong_buffer_ctrl: RTL and testbench
=======================================

# pingpong_buffer_ctrl

Sequencing controller for the two 32x8 ping-pong RAM banks behind the VGA/game data path. Accepts a stream of bytes from a producer, fills one bank while the consumer drains the other, and swaps bank roles only when a bank is completely written or completely read. It owns all RAM enables and addresses, and presents a simple valid/ready write port and a request/valid read port to the surrounding logic.

## Interface
- DEPTH, 32, entries per bank; power of two
- AW, 5, address width, log2(DEPTH)
- DW, 8, data width
- clk  in  1  single clock for all logic and both RAM banks
- resetn  in  1  synchronous, active-low reset, sampled on rising clk
- wr_valid  in  1  producer has a byte
- wr_data  in  DW  producer byte
- wr_ready  out  1  controller can accept the byte this cycle
- rd_req  in  1  consumer requests next byte
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  DW  returned byte; holds between pulses
- rd_last  out  1  high with rd_valid for entry DEPTH-1 of a bank
- underrun  out  1  one-cycle pulse: rd_req with no full bank
- frame_swap  out  1  one-cycle pulse: read bank released
- swap_count  out  8  count of released banks, wraps 255->0
- fill_bank / drain_bank  out  1 each  current write / read bank index
- bankN_we, bankN_re  out  1  (N=0,1) RAM write / read enables
- bankN_waddr, bankN_raddr  out  AW  RAM addresses
- bankN_wdata  out  DW  RAM write data
- bankN_rdata  in  DW  RAM read data, 1-cycle synchronous read

## Operation
- State: full[1:0] flags, wbank, rbank, wptr, rptr (AW bits each), read pipeline valid bit and bank tag.
- Write: wr_ready = !full[wbank] (registered state only, no dependency on wr_valid). On wr_valid && wr_ready: bank[wbank]_we=1, waddr=wptr, wdata=wr_data; wptr++. When wptr==DEPTH-1 is written: wptr<=0, full[wbank]<=1, wbank<=~wbank.
- Read: on rd_req && full[rbank]: bank[rbank]_re=1, raddr=rptr; rptr++. When rptr==DEPTH-1 is issued: rptr<=0, full[rbank]<=0, rbank<=~rbank, frame_swap pulse, swap_count++.
- rd_req && !full[rbank]: no RAM access, underrun pulse next cycle, pointers unchanged.
- Writer never targets a full bank and reader only targets a full bank, so both ports never touch the same bank in one cycle.
- Simultaneous bank-complete on write and bank-release on read in one cycle: both flag updates apply (distinct bits).
- Writer stalled on bank just released: wr_ready rises the cycle after release.
- Unused enables are 0; unused addresses/wdata are 0.
- fill_bank=wbank, drain_bank=rbank.

## Timing
- Reset (resetn=0 at edge): all flags, pointers, banks, swap_count, rd_data cleared to 0; every output 0 except wr_ready=1 after reset. Bank contents are discarded logically. A read issued in the cycle before reset produces no rd_valid.
- Write: accepted byte is in RAM at the same edge; zero-cycle acceptance.
- Read latency: rd_req in cycle k -> re/raddr driven in k, rdata in k+1, registered -> rd_valid, rd_data, rd_last in cycle k+2.
- Throughput: one write and one read per cycle, back-to-back, including across a swap boundary (entry 0 of the next bank can be requested the cycle after entry DEPTH-1 if that bank is full).
- frame_swap and swap_count update at the edge ending the issue cycle of entry DEPTH-1; precedes the matching rd_last by one cycle.
- underrun: registered, cycle k+1 after offending rd_req.

## Test plan
- Reset then 32 writes 0x00..0x1F with wr_valid held -> bank0 filled, wbank=1, full=01, wr_ready stays 1.
- Then 32 consecutive rd_req -> rd_data 0x00..0x1F at k+2..k+33, rd_last on 0x1F only, frame_swap once, swap_count=1, drain_bank=1.
- Write 64 bytes with no reads -> wr_ready drops after 64th; 65th byte held; one rd_req burst of 32 frees bank0, wr_ready=1 next cycle and the 65th byte lands at bank0 addr 0.
- rd_req with both banks empty -> underrun pulse one cycle later, no rd_valid, rptr unchanged.
- Concurrent streaming (write and read each cycle, 300 frames) -> data order preserved, swap_count wraps to 300 mod 256=44, no underrun after first fill.
- Assert resetn=0 mid-drain (rptr=10) -> next cycle all outputs at reset values, no rd_valid from in-flight read, subsequent fill/drain correct from addr 0.

Source files
------------

// File: rtl/pingpong_buffer_ctrl.sv
// pingpong_buffer_ctrl
//   Sequencer for two DEPTH x DW ping-pong RAM banks. The producer fills one
//   bank while the consumer drains the other. Bank roles swap only when a bank
//   has been completely written (write side) or completely read (read side).
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   wr_valid/wr_data/wr_ready   producer byte stream (zero-cycle acceptance)
//   rd_req                      consumer request for the next byte
//   rd_valid/rd_data/rd_last    returned byte, two cycles after rd_req
//   underrun                    pulse: rd_req seen while no bank was full
//   frame_swap, swap_count      pulse / running count of released read banks
//   fill_bank, drain_bank       current write / read bank index
//   bankN_*                     RAM enables, addresses, write data, read data
module pingpong_buffer_ctrl #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          underrun,
    output logic          frame_swap,
    output logic [7:0]    swap_count,
    output logic          fill_bank,
    output logic          drain_bank,
    output logic          bank0_we,
    output logic          bank0_re,
    output logic [AW-1:0] bank0_waddr,
    output logic [AW-1:0] bank0_raddr,
    output logic [DW-1:0] bank0_wdata,
    input  logic [DW-1:0] bank0_rdata,
    output logic          bank1_we,
    output logic          bank1_re,
    output logic [AW-1:0] bank1_waddr,
    output logic [AW-1:0] bank1_raddr,
    output logic [DW-1:0] bank1_wdata,
    input  logic [DW-1:0] bank1_rdata
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [1:0]    full_q, full_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    // Read pipeline: issue stage (RAM access in flight) then output stage.
    logic          rd_pend_q, rd_pend_d;
    logic          rd_tag_q, rd_tag_d;
    logic          rd_pend_last_q, rd_pend_last_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_last_q, rd_last_d;
    logic          underrun_q, underrun_d;
    logic          frame_swap_q, frame_swap_d;
    logic [7:0]    swap_count_q, swap_count_d;

    logic wr_fire, rd_fire, wr_wrap, rd_wrap;

    always_comb begin
        wr_ready = !full_q[wbank_q];
        wr_fire  = wr_valid && !full_q[wbank_q];
        rd_fire  = rd_req && full_q[rbank_q];
        wr_wrap  = wr_fire && (wptr_q == LAST);
        rd_wrap  = rd_fire && (rptr_q == LAST);

        full_d       = full_q;
        wbank_d      = wbank_q;
        rbank_d      = rbank_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        swap_count_d = swap_count_q;

        bank0_we    = 1'b0;
        bank0_waddr = '0;
        bank0_wdata = '0;
        bank1_we    = 1'b0;
        bank1_waddr = '0;
        bank1_wdata = '0;
        bank0_re    = 1'b0;
        bank0_raddr = '0;
        bank1_re    = 1'b0;
        bank1_raddr = '0;

        if (wr_fire) begin
            if (wbank_q) begin
                bank1_we    = 1'b1;
                bank1_waddr = wptr_q;
                bank1_wdata = wr_data;
            end else begin
                bank0_we    = 1'b1;
                bank0_waddr = wptr_q;
                bank0_wdata = wr_data;
            end
            wptr_d = wptr_q + AW'(1);
            if (wr_wrap) begin
                wptr_d          = '0;
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end

        // The writer only targets an empty bank and the reader only a full
        // one, so the two flag updates below always touch different bits.
        if (rd_fire) begin
            if (rbank_q) begin
                bank1_re    = 1'b1;
                bank1_raddr = rptr_q;
            end else begin
                bank0_re    = 1'b1;
                bank0_raddr = rptr_q;
            end
            rptr_d = rptr_q + AW'(1);
            if (rd_wrap) begin
                rptr_d          = '0;
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                swap_count_d    = swap_count_q + 8'd1;
            end
        end

        frame_swap_d   = rd_wrap;
        underrun_d     = rd_req && !full_q[rbank_q];
        rd_pend_d      = rd_fire;
        rd_tag_d       = rbank_q;
        rd_pend_last_d = rd_wrap;

        rd_valid_d = rd_pend_q;
        rd_last_d  = rd_pend_q && rd_pend_last_q;
        rd_data_d  = rd_data_q;
        if (rd_pend_q) begin
            rd_data_d = rd_tag_q ? bank1_rdata : bank0_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            full_q         <= '0;
            wbank_q        <= 1'b0;
            rbank_q        <= 1'b0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            rd_pend_q      <= 1'b0;
            rd_tag_q       <= 1'b0;
            rd_pend_last_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_last_q      <= 1'b0;
            underrun_q     <= 1'b0;
            frame_swap_q   <= 1'b0;
            swap_count_q   <= '0;
        end else begin
            full_q         <= full_d;
            wbank_q        <= wbank_d;
            rbank_q        <= rbank_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            rd_pend_q      <= rd_pend_d;
            rd_tag_q       <= rd_tag_d;
            rd_pend_last_q <= rd_pend_last_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_last_q      <= rd_last_d;
            underrun_q     <= underrun_d;
            frame_swap_q   <= frame_swap_d;
            swap_count_q   <= swap_count_d;
        end
    end

    always_comb begin
        rd_valid   = rd_valid_q;
        rd_data    = rd_data_q;
        rd_last    = rd_last_q;
        underrun   = underrun_q;
        frame_swap = frame_swap_q;
        swap_count = swap_count_q;
        fill_bank  = wbank_q;
        drain_bank = rbank_q;
    end

endmodule

// File: tb/tb_pingpong_buffer_ctrl.sv
// tb_pingpong_buffer_ctrl
//   Directed bench for pingpong_buffer_ctrl with two behavioural 32x8 RAMs
//   (synchronous write, 1-cycle synchronous read) attached to the bank ports.
module tb_pingpong_buffer_ctrl;

    logic       clk;
    logic       resetn;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       underrun;
    logic       frame_swap;
    logic [7:0] swap_count;
    logic       fill_bank;
    logic       drain_bank;
    logic       b0_we, b0_re, b1_we, b1_re;
    logic [4:0] b0_waddr, b0_raddr, b1_waddr, b1_raddr;
    logic [7:0] b0_wdata, b1_wdata, b0_rdata, b1_rdata;

    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];

    int tests = 0;
    int fails = 0;

    pingpong_buffer_ctrl #(.DEPTH(32), .AW(5), .DW(8)) dut (
        .clk(clk), .resetn(resetn),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .underrun(underrun), .frame_swap(frame_swap), .swap_count(swap_count),
        .fill_bank(fill_bank), .drain_bank(drain_bank),
        .bank0_we(b0_we), .bank0_re(b0_re), .bank0_waddr(b0_waddr),
        .bank0_raddr(b0_raddr), .bank0_wdata(b0_wdata), .bank0_rdata(b0_rdata),
        .bank1_we(b1_we), .bank1_re(b1_re), .bank1_waddr(b1_waddr),
        .bank1_raddr(b1_raddr), .bank1_wdata(b1_wdata), .bank1_rdata(b1_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b0_we) mem0[b0_waddr] <= b0_wdata;
        if (b0_re) b0_rdata <= mem0[b0_raddr];
        if (b1_we) mem1[b1_waddr] <= b1_wdata;
        if (b1_re) b1_rdata <= mem1[b1_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
        tick(); tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        resetn = 1'b0;
        tick();
        tests++;
        if ({wr_ready, rd_valid, rd_last, underrun, frame_swap} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 10000",
                     {wr_ready, rd_valid, rd_last, underrun, frame_swap});
        end
        tests++;
        if ({swap_count, fill_bank, drain_bank, rd_data} !== 18'h0) begin
            fails++;
            $display("FAIL reset_state: swap=%h fill=%b drain=%b rd_data=%h expected all 0",
                     swap_count, fill_bank, drain_bank, rd_data);
        end
        tests++;
        if ({b0_we, b0_re, b1_we, b1_re, b0_waddr, b0_raddr, b1_waddr, b1_raddr,
             b0_wdata, b1_wdata} !== 40'h0) begin
            fails++;
            $display("FAIL reset_bank_ports: got %h expected 0",
                     {b0_we, b0_re, b1_we, b1_re, b0_waddr, b0_raddr, b1_waddr,
                      b1_raddr, b0_wdata, b1_wdata});
        end
        resetn = 1'b1;
    endtask

    task automatic test_fill();
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            v = 8'(i);
            wr_valid = 1'b1; wr_data = v;
            #1;
            tests++;
            if ({wr_ready, b0_we, b1_we, b0_waddr, b0_wdata} !== {3'b110, v[4:0], v}) begin
                fails++;
                $display("FAIL fill_write[%0d]: got %h expected %h", i,
                         {wr_ready, b0_we, b1_we, b0_waddr, b0_wdata}, {3'b110, v[4:0], v});
            end
            tick();
        end
        wr_valid = 1'b0;
        #1;
        tests++;
        if ({fill_bank, drain_bank, wr_ready} !== 3'b101) begin
            fails++;
            $display("FAIL fill_end: fill/drain/ready got %b expected 101",
                     {fill_bank, drain_bank, wr_ready});
        end
    endtask

    task automatic test_drain();
        logic ev, el, ef;
        for (int i = 0; i < 34; i++) begin
            rd_req = (i < 32);
            tick();
            ev = (i >= 1 && i <= 32);
            el = (i == 32);
            ef = (i == 31);
            tests++;
            if ({rd_valid, rd_last, frame_swap, underrun} !== {ev, el, ef, 1'b0}) begin
                fails++;
                $display("FAIL drain_flags[%0d]: valid/last/swap/under got %b expected %b",
                         i, {rd_valid, rd_last, frame_swap, underrun}, {ev, el, ef, 1'b0});
            end
            if (ev) begin
                tests++;
                if (rd_data !== 8'(i - 1)) begin
                    fails++;
                    $display("FAIL drain_data[%0d]: got %h expected %h", i, rd_data, 8'(i - 1));
                end
            end
        end
        tests++;
        if ({swap_count, drain_bank, fill_bank} !== {8'd1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL drain_end: swap=%0d drain=%b fill=%b expected 1 1 1",
                     swap_count, drain_bank, fill_bank);
        end
    endtask

    task automatic test_underrun();
        rd_req = 1'b1;
        #1;
        tests++;
        if ({b0_re, b1_re} !== 2'b00) begin
            fails++;
            $display("FAIL underrun_no_access: re got %b expected 00", {b0_re, b1_re});
        end
        tick();
        rd_req = 1'b0;
        tests++;
        if ({underrun, rd_valid} !== 2'b10) begin
            fails++;
            $display("FAIL underrun_pulse: under/valid got %b expected 10", {underrun, rd_valid});
        end
        tick();
        tests++;
        if ({underrun, rd_valid} !== 2'b00) begin
            fails++;
            $display("FAIL underrun_clear: under/valid got %b expected 00", {underrun, rd_valid});
        end
        // Fill bank1, then the first read must start at address 0.
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h60 + i);
            tick();
        end
        wr_valid = 1'b0;
        rd_req = 1'b1;
        #1;
        tests++;
        if ({b1_re, b0_re, b1_raddr} !== {2'b10, 5'd0}) begin
            fails++;
            $display("FAIL underrun_rptr: re1/re0/raddr got %h expected %h",
                     {b1_re, b0_re, b1_raddr}, {2'b10, 5'd0});
        end
        tick();
        rd_req = 1'b0;
        tick();
        tests++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h60}) begin
            fails++;
            $display("FAIL underrun_first_read: got %h expected %h", {rd_valid, rd_data},
                     {1'b1, 8'h60});
        end
    endtask

    task automatic test_back_to_back();
        logic ev, el, ef, ew;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i);
            #1;
            tests++;
            if (wr_ready !== 1'b1) begin
                fails++;
                $display("FAIL bp_ready[%0d]: got %b expected 1", i, wr_ready);
            end
            tick();
        end
        wr_data = 8'hAA;
        for (int i = 0; i < 66; i++) begin
            rd_req = (i < 64);
            #1;
            if (i <= 32) begin
                ew = (i == 32);
                tests++;
                if ({b0_we, b1_we} !== {ew, 1'b0}) begin
                    fails++;
                    $display("FAIL bp_stall_we[%0d]: we0/we1 got %b expected %b", i,
                             {b0_we, b1_we}, {ew, 1'b0});
                end
                if (ew) begin
                    tests++;
                    if ({b0_waddr, b0_wdata} !== {5'd0, 8'hAA}) begin
                        fails++;
                        $display("FAIL bp_65th: addr/data got %h expected %h",
                                 {b0_waddr, b0_wdata}, {5'd0, 8'hAA});
                    end
                end
            end
            tick();
            if (i == 32) wr_valid = 1'b0;
            if (i <= 31) begin
                tests++;
                if (wr_ready !== (i == 31)) begin
                    fails++;
                    $display("FAIL bp_ready_rise[%0d]: got %b expected %b", i, wr_ready, i == 31);
                end
            end
            ev = (i >= 1 && i <= 64);
            el = (i == 32 || i == 64);
            ef = (i == 31 || i == 63);
            tests++;
            if ({rd_valid, rd_last, frame_swap} !== {ev, el, ef}) begin
                fails++;
                $display("FAIL b2b_flags[%0d]: valid/last/swap got %b expected %b", i,
                         {rd_valid, rd_last, frame_swap}, {ev, el, ef});
            end
            if (ev) begin
                tests++;
                if (rd_data !== 8'(i - 1)) begin
                    fails++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd_data, 8'(i - 1));
                end
            end
        end
        tests++;
        if ({swap_count, mem0[0]} !== {8'd2, 8'hAA}) begin
            fails++;
            $display("FAIL bp_end: swap=%0d mem0[0]=%h expected 2 aa", swap_count, mem0[0]);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h80 + i);
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            rd_req = 1'b1;
            if (i == 10) resetn = 1'b0;
            tick();
            if (i >= 1 && i < 10) begin
                tests++;
                if ({rd_valid, rd_data} !== {1'b1, 8'(8'h80 + i - 1)}) begin
                    fails++;
                    $display("FAIL mid_pre[%0d]: got %h expected %h", i, {rd_valid, rd_data},
                             {1'b1, 8'(8'h80 + i - 1)});
                end
            end
        end
        tests++;
        if ({rd_valid, rd_last, underrun, frame_swap, wr_ready, fill_bank, drain_bank,
             swap_count, rd_data} !== {7'b0000100, 16'h0}) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %h expected %h",
                     {rd_valid, rd_last, underrun, frame_swap, wr_ready, fill_bank, drain_bank,
                      swap_count, rd_data}, {7'b0000100, 16'h0});
        end
        resetn = 1'b1;
        rd_req = 1'b0;
        tick();
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_inflight: rd_valid got %b expected 0", rd_valid);
        end
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'hC0 + i);
            #1;
            tests++;
            if ({b0_we, b0_waddr} !== {1'b1, 5'(i)}) begin
                fails++;
                $display("FAIL mid_refill[%0d]: we/addr got %h expected %h", i,
                         {b0_we, b0_waddr}, {1'b1, 5'(i)});
            end
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 34; i++) begin
            rd_req = (i < 32);
            tick();
            if (i >= 1 && i <= 32) begin
                tests++;
                if ({rd_valid, rd_last, rd_data} !== {1'b1, i == 32, 8'(8'hC0 + i - 1)}) begin
                    fails++;
                    $display("FAIL mid_redrain[%0d]: got %h expected %h", i,
                             {rd_valid, rd_last, rd_data}, {1'b1, i == 32, 8'(8'hC0 + i - 1)});
                end
            end
        end
    endtask

    task automatic test_streaming();
        int wn, rn, got, under, stalls;
        wn = 0; rn = 0; got = 0; under = 0; stalls = 0;
        do_reset();
        for (int cyc = 0; cyc < 9600 + 40; cyc++) begin
            wr_valid = (wn < 9600);
            wr_data  = 8'(wn);
            rd_req   = (cyc >= 32 && rn < 9600);
            #1;
            if (wr_valid) begin
                if (wr_ready) wn++;
                else stalls++;
            end
            if (rd_req) rn++;
            tick();
            if (rd_valid) begin
                tests++;
                if (rd_data !== 8'(got)) begin
                    fails++;
                    $display("FAIL stream_data[%0d]: got %h expected %h", got, rd_data, 8'(got));
                end
                got++;
            end
            if (underrun) under++;
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        tests++;
        if (got != 9600) begin
            fails++;
            $display("FAIL stream_count: got %0d reads expected 9600", got);
        end
        tests++;
        if ({under, stalls} != 64'd0) begin
            fails++;
            $display("FAIL stream_underrun_stall: under=%0d stalls=%0d expected 0 0", under, stalls);
        end
        tests++;
        if (swap_count !== 8'd44) begin
            fails++;
            $display("FAIL stream_swap_wrap: got %0d expected 44", swap_count);
        end
    endtask

    initial begin
        resetn = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_underrun();
        test_back_to_back();
        test_reset_mid_drain();
        test_streaming();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
